// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the iterative 16-bit divider.
// The SIGNED_DIV_EN build uses the NEG state; the unsigned build never reaches it.
package div_pkg;

   localparam int DIV_W     = 16;
   localparam int DIV_CNT_W = 5;

   localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/Adder16Bit.sv
// 16-bit ripple-carry adder; subtraction is done by the caller inverting b_i and setting cin_i.
module Adder16Bit
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] a_i,
   input  logic [DIV_W-1:0] b_i,
   input  logic             cin_i,
   output logic [DIV_W-1:0] sum_o,
   output logic             cout_o
);

   logic carry;

   always_comb begin
      carry = cin_i;
      sum_o = '0;
      for (int i = 0; i < DIV_W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/div_step16.sv
// One restoring-division step: shift the next dividend bit into R and try subtracting D.
module div_step16
   import div_pkg::*;
(
   input  logic [DIV_W-1:0] r_i,
   input  logic             q_msb_i,
   input  logic [DIV_W-1:0] d_i,
   output logic [DIV_W-1:0] r_o,
   output logic             q_bit_o
);

   logic [DIV_W:0]   r_sh;
   logic [DIV_W-1:0] trial;
   logic             carry;

   // R stays below D between steps, so only the shifted value needs the extra bit.
   assign r_sh = {r_i, q_msb_i};

   Adder16Bit u_sub (
      .a_i   (r_sh[DIV_W-1:0]),
      .b_i   (~d_i),
      .cin_i (1'b1),
      .sum_o (trial),
      .cout_o(carry)
   );

   // A set top bit means R' already exceeds any 16-bit D, even though the 16-bit adder borrowed.
   assign q_bit_o = carry | r_sh[DIV_W];
   assign r_o     = q_bit_o ? trial : r_sh[DIV_W-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Iterative restoring divider, one quotient bit per clock, start/ready/done handshake.
// Define SIGNED_DIV_EN to add signed_i and the NEG sign-correction state.
module seq_divider16
   import div_pkg::*;
#(
   parameter int W     = DIV_W,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
`ifdef SIGNED_DIV_EN
   input  logic         signed_i,
`endif
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] quotient_o,
   output logic [W-1:0] remainder_o,
   output logic         div_zero_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     r_q, r_d, q_q, q_d, d_q, d_d;
   logic [W-1:0]     quot_q, quot_d, rem_q, rem_d;
   logic             dz_q, dz_d;
   logic [W-1:0]     r_step, q_shift, dvd_mag, dvs_mag;
   logic             q_bit;

   div_step16 u_step (
      .r_i    (r_q),
      .q_msb_i(q_q[W-1]),
      .d_i    (d_q),
      .r_o    (r_step),
      .q_bit_o(q_bit)
   );

   assign q_shift = {q_q[W-2:0], q_bit};

`ifdef SIGNED_DIV_EN
   logic         sgn_q, sgn_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic [W-1:0] neg_a_in, neg_b_in, neg_a, neg_b;
   logic         neg_a_cout_unused, neg_b_cout_unused;

   // The same negators take the operands at accept and the raw results in NEG.
   assign neg_a_in = (state_q == IDLE) ? dividend_i : q_q;
   assign neg_b_in = (state_q == IDLE) ? divisor_i  : r_q;

   Adder16Bit u_neg_a (
      .a_i('0), .b_i(~neg_a_in), .cin_i(1'b1), .sum_o(neg_a), .cout_o(neg_a_cout_unused)
   );
   Adder16Bit u_neg_b (
      .a_i('0), .b_i(~neg_b_in), .cin_i(1'b1), .sum_o(neg_b), .cout_o(neg_b_cout_unused)
   );

   assign dvd_mag = (signed_i && dividend_i[W-1]) ? neg_a : dividend_i;
   assign dvs_mag = (signed_i && divisor_i[W-1])  ? neg_b : divisor_i;
`else
   assign dvd_mag = dividend_i;
   assign dvs_mag = divisor_i;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
      sgn_d   = sgn_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (divisor_i == '0) begin
                  quot_d  = DIV_ZERO_QUOT;
                  rem_d   = dividend_i;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  q_d     = dvd_mag;
                  d_d     = dvs_mag;
                  r_d     = '0;
                  cnt_d   = '0;
                  state_d = RUN;
`ifdef SIGNED_DIV_EN
                  sgn_d   = signed_i;
                  neg_q_d = signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
                  neg_r_d = signed_i & dividend_i[W-1];
`endif
               end
            end
         end
         RUN: begin
            r_d   = r_step;
            q_d   = q_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
`ifdef SIGNED_DIV_EN
               if (sgn_q) state_d = NEG;
               else
`endif
               begin
                  state_d = DONE;
                  quot_d  = q_shift;
                  rem_d   = r_step;
                  dz_d    = 1'b0;
               end
            end
         end
`ifdef SIGNED_DIV_EN
         NEG: begin
            quot_d  = neg_q_q ? neg_a : q_q;
            rem_d   = neg_r_q ? neg_b : r_q;
            dz_d    = 1'b0;
            state_d = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
         sgn_q   <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
`ifdef SIGNED_DIV_EN
         sgn_q   <= sgn_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

   assign ready_o     = (state_q == IDLE);
   assign busy_o      = (state_q == RUN) || (state_q == NEG);
   assign done_o      = (state_q == DONE);
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases, handshake timing and random operands
// checked against an arithmetic reference model (signed cases only when SIGNED_DIV_EN is defined).
module tb_seq_divider16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [15:0] dvd = '0;
   logic [15:0] dvs = '0;
   logic        ready_o, busy_o, done_o, div_zero_o;
   logic [15:0] quotient_o, remainder_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_divider16 dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
`ifdef SIGNED_DIV_EN
      .signed_i   (sgn),
`endif
      .dividend_i (dvd),
      .divisor_i  (dvs),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .quotient_o (quotient_o),
      .remainder_o(remainder_o),
      .div_zero_o (div_zero_o)
   );

   // Reference: plain arithmetic; signed uses int division (truncating, remainder follows dividend).
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic dz, output int lat);
      int sa, sb;
      if (b == 16'd0) begin
         q = 16'hFFFF; r = a; dz = 1'b1; lat = 0;
      end else if (s) begin
         sa = $signed(a); sb = $signed(b);
         q = 16'(sa / sb); r = 16'(sa % sb); dz = 1'b0; lat = 17;
      end else begin
         q = a / b; r = a % b; dz = 1'b0; lat = 16;
      end
   endfunction

   // Waits for ready, issues one request, returns results and edges from accept to done.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      dvd = a; dvs = b; sgn = s; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done_o && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      total++;
      if (!done_o) begin
         bad++;
         $display("FAIL op_timeout: a=%h b=%h got no done after %0d edges, want done", a, b, lat);
      end
      q = quotient_o; r = remainder_o; dz = div_zero_o;
   endtask

   task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic s);
      logic [15:0] q, r, eq, er;
      logic        dz, edz;
      int          lat, elat;
      model(a, b, s, eq, er, edz, elat);
      run_op(a, b, s, q, r, dz, lat);
      total++;
      if (q !== eq) begin
         bad++;
         $display("FAIL %s_quot: a=%h b=%h got %h want %h", name, a, b, q, eq);
      end
      total++;
      if (r !== er) begin
         bad++;
         $display("FAIL %s_rem: a=%h b=%h got %h want %h", name, a, b, r, er);
      end
      total++;
      if (dz !== edz) begin
         bad++;
         $display("FAIL %s_dz: a=%h b=%h got %b want %b", name, a, b, dz, edz);
      end
      total++;
      if (lat != elat) begin
         bad++;
         $display("FAIL %s_latency: a=%h b=%h got %0d edges want %0d", name, a, b, lat, elat);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
      total++; if (quotient_o !== 16'h0) begin bad++; $display("FAIL reset_quot: got %h want 0", quotient_o); end
      total++; if (remainder_o !== 16'h0) begin bad++; $display("FAIL reset_rem: got %h want 0", remainder_o); end
      total++; if (div_zero_o !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [15:0] q0, r0;
      check_op("basic", 16'd1000, 16'd7, 1'b0);
      q0 = quotient_o; r0 = remainder_o;
      total++;
      if (q0 !== 16'd142 || r0 !== 16'd6) begin
         bad++;
         $display("FAIL basic_const: got q=%0d r=%0d want q=142 r=6", q0, r0);
      end
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (quotient_o !== 16'd142 || remainder_o !== 16'd6 || !ready_o) begin
         bad++;
         $display("FAIL basic_hold: got q=%0d r=%0d ready=%b want q=142 r=6 ready=1",
                  quotient_o, remainder_o, ready_o);
      end
   endtask

   task automatic test_boundaries;
      logic [15:0] ta[6] = '{16'hFFFF, 16'd5, 16'd0, 16'hFFFF, 16'd1, 16'h8000};
      logic [15:0] tb[6] = '{16'd1, 16'd9, 16'd3, 16'hFFFF, 16'hFFFF, 16'd2};
      for (int i = 0; i < 6; i++) check_op("boundary", ta[i], tb[i], 1'b0);
   endtask

   task automatic test_div_zero;
      check_op("divzero", 16'd1234, 16'd0, 1'b0);
      check_op("after_divzero", 16'd10, 16'd3, 1'b0);
   endtask

   task automatic test_reset_mid;
      logic saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      dvd = 16'd1000; dvs = 16'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1 if (done_o) saw_done = 1'b1;
      end
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (!ready_o || busy_o || done_o || quotient_o !== 16'h0 || remainder_o !== 16'h0 || div_zero_o) begin
         bad++;
         $display("FAIL midreset_state: got ready=%b busy=%b done=%b q=%h r=%h dz=%b want 1 0 0 0 0 0",
                  ready_o, busy_o, done_o, quotient_o, remainder_o, div_zero_o);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1 if (done_o || busy_o) saw_done = 1'b1;
      end
      total++;
      if (saw_done) begin
         bad++;
         $display("FAIL midreset_abort: got done/busy after abort=1 want 0");
      end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      int cyc;
      logic prev_busy;
      cyc = 0; prev_busy = 1'b0;
      @(negedge clk);
      while (!ready_o && cyc < 50) begin @(negedge clk); cyc++; end
      cyc = 0;
      dvd = 16'd100; dvs = 16'd7; sgn = 1'b0; start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1 cyc++;
         if (busy_o && !prev_busy) acc.push_back(cyc);
         prev_busy = busy_o;
         total++;
         if ((ready_o && busy_o) || (done_o && (ready_o || busy_o))) begin
            bad++;
            $display("FAIL b2b_exclusive: got ready=%b busy=%b done=%b", ready_o, busy_o, done_o);
         end
         if (done_o) begin
            total++;
            if (quotient_o !== 16'd14 || remainder_o !== 16'd2) begin
               bad++;
               $display("FAIL b2b_result: got q=%0d r=%0d want q=14 r=2", quotient_o, remainder_o);
            end
         end
      end
      @(negedge clk) start = 1'b0;
      total++;
      if (acc.size() < 3) begin
         bad++;
         $display("FAIL b2b_count: got %0d accepts want >=3", acc.size());
      end
      for (int k = 1; k < acc.size(); k++) begin
         total++;
         if (acc[k] - acc[k-1] != 18) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles want 18", acc[k] - acc[k-1]);
         end
      end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_ignored_start;
      int lat;
      logic saw_busy;
      saw_busy = 1'b0;
      @(negedge clk);
      while (!ready_o) @(negedge clk);
      dvd = 16'd1000; dvs = 16'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done_o && lat < 40) begin
         @(posedge clk);
         #1 lat++;
         if (lat == 5) begin dvd = 16'd50; dvs = 16'd5; start = 1'b1; end
         if (lat == 7) start = 1'b0;
      end
      start = 1'b0;
      total++;
      if (lat != 16 || quotient_o !== 16'd142 || remainder_o !== 16'd6) begin
         bad++;
         $display("FAIL ignored_start: got lat=%0d q=%0d r=%0d want 16 142 6", lat, quotient_o, remainder_o);
      end
      repeat (25) begin
         @(posedge clk);
         #1 if (busy_o) saw_busy = 1'b1;
      end
      total++;
      if (saw_busy) begin
         bad++;
         $display("FAIL ignored_queue: got busy=1 after done want 0");
      end
   endtask

   task automatic test_random;
      logic [15:0] a, b, q, r, eq, er;
      logic        dz, edz;
      int          lat, elat, k;
      longint      recon;
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom_range(0, 65535));
         k = $urandom_range(0, 63);
         if (k == 0) b = 16'd0;
         else if (k < 16) b = 16'($urandom_range(1, 15));
         else b = 16'($urandom_range(1, 65535));
         model(a, b, 1'b0, eq, er, edz, elat);
         run_op(a, b, 1'b0, q, r, dz, lat);
         total++;
         if (q !== eq || r !== er || dz !== edz || lat != elat) begin
            bad++;
            $display("FAIL rand_op: a=%h b=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                     a, b, q, r, dz, lat, eq, er, edz, elat);
         end
         if (b != 16'd0) begin
            recon = longint'(q) * longint'(b) + longint'(r);
            total++;
            if (recon != longint'(a) || r >= b) begin
               bad++;
               $display("FAIL rand_invariant: a=%h b=%h got q=%h r=%h want q*b+r=a, r<b", a, b, q, r);
            end
         end
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed;
      logic [15:0] a, b;
      logic [15:0] sa[6] = '{16'hFFF9, 16'h8000, 16'd7, 16'hFFF9, 16'h8000, 16'hFFFB};
      logic [15:0] sb[6] = '{16'd2, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'd1, 16'd0};
      for (int i = 0; i < 6; i++) check_op("signed", sa[i], sb[i], 1'b1);
      check_op("signed_m7d2", 16'hFFF9, 16'd2, 1'b1);
      total++;
      if (quotient_o !== 16'hFFFD || remainder_o !== 16'hFFFF) begin
         bad++;
         $display("FAIL signed_m7d2_const: got q=%h r=%h want q=fffd r=ffff", quotient_o, remainder_o);
      end
      check_op("signed_min", 16'h8000, 16'hFFFF, 1'b1);
      total++;
      if (quotient_o !== 16'h8000 || remainder_o !== 16'h0000) begin
         bad++;
         $display("FAIL signed_min_const: got q=%h r=%h want q=8000 r=0000", quotient_o, remainder_o);
      end
      for (int i = 0; i < 400; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = ($urandom_range(0, 31) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         check_op("signed_rand", a, b, 1'b1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_reset_mid();
      test_back_to_back();
      test_ignored_start();
      test_random();
`ifdef SIGNED_DIV_EN
      test_signed();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
